// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   UART_DATA_BITS : data bits per frame, sent LSB first
//   uart_state_e   : receiver FSM state encodings
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_START = 3'b001,
    ST_DATA  = 3'b010,
    ST_STOP  = 3'b011,
    ST_BREAK = 3'b100
  } uart_state_e;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen: free-running oversample strobe generator.
// The counter runs 0..DIV-1, where DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE)
// and the division truncates. sample_tick is high for the one clk where the
// counter sits at DIV-1.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   sample_tick : one-clk strobe at OVERSAMPLE x baud
module uart_rx_tick_gen #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic sample_tick
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Divider counter, wraps after the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign sample_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with 16x oversampling and valid/ready output.
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   rx_pin        : asynchronous serial input, idle high
//   rx_data       : received byte, held while rx_valid is high
//   rx_valid      : byte available
//   rx_ready      : consumer accepts the byte
//   frame_error   : one-clk pulse when the stop bit samples low
//   overrun_error : one-clk pulse when a byte completes while one is still pending
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_pin,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_error,
  output logic                      overrun_error
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0]  TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(UART_DATA_BITS - 1);

  logic                      r_sync1, r_rx_sync;
  logic                      w_sample_tick;
  uart_state_e               r_state, w_state_nxt;
  logic [TW-1:0]             r_tick_cnt, w_tick_nxt;
  logic [BCW-1:0]            r_bit_cnt, w_bit_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                      w_deliver, w_frame_err;

  uart_rx_tick_gen #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_gen (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (w_sample_tick)
  );

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_sync1   <= rx_pin;
      r_rx_sync <= r_sync1;
    end
  end

  // FSM state, counters and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  // Next-state logic; everything advances only on sample_tick.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_frame_err = 1'b0;
    if (w_sample_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_sync) begin
            w_state_nxt = ST_START;
            w_tick_nxt  = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_START: begin
          // Half a bit in: a line that has gone high again was a glitch.
          if (r_tick_cnt == TICK_HALF) begin
            w_tick_nxt = '0;
            w_bit_nxt  = '0;
            if (!r_rx_sync) begin
              w_state_nxt = ST_DATA;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        ST_DATA: begin
          // Counting a full bit from mid-start lands on each data bit's centre.
          if (r_tick_cnt == TICK_LAST) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {r_rx_sync, r_shift[UART_DATA_BITS-1:1]};
            w_bit_nxt   = r_bit_cnt + BCW'(1);
            if (r_bit_cnt == BIT_LAST) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        ST_STOP: begin
          if (r_tick_cnt == TICK_LAST) begin
            w_tick_nxt = '0;
            if (r_rx_sync) begin
              w_deliver   = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_frame_err = 1'b1;
              w_state_nxt = ST_BREAK;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TW'(1);
          end
        end
        ST_BREAK: begin
          // Wait out a held-low line so it cannot be taken as new start bits.
          if (r_rx_sync) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_BREAK;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Output register: byte delivery, handshake and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      frame_error   <= w_frame_err;
      overrun_error <= w_deliver & rx_valid & ~rx_ready;
      // A byte arriving in the same cycle as a transfer replaces the old one.
      if (w_deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 10_000;
  localparam int OS      = 16;
  localparam int BIT_CLK = CLK_HZ / BAUD;   // 160 clk per bit

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun_error;

  int vectors     = 0;
  int miscompares = 0;

  // Observed behaviour, collected by the monitor.
  logic [7:0] got_q[$];
  longint     got_t[$];
  int         fe_cnt    = 0;
  int         ov_cnt    = 0;
  int         valid_cyc = 0;
  longint     cyc       = 0;

  // Reference model: bytes the specification says must be handed over.
  logic [7:0] exp_q[$];

  uart_receiver #(
    .CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_error   (frame_error),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) valid_cyc <= valid_cyc + 1;
      if (rx_valid && rx_ready) begin
        got_q.push_back(rx_data);
        got_t.push_back(cyc);
      end
      if (frame_error)   fe_cnt <= fe_cnt + 1;
      if (overrun_error) ov_cnt <= ov_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial frame: start low, 8 data bits LSB first, stop bit, line left idle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
    rx_pin = 1'b0;
    repeat (per) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (per) @(posedge clk);
    end
    rx_pin = stop_bit;
    repeat (per) @(posedge clk);
    rx_pin = 1'b1;
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
    got_t.delete();
  endtask

  initial begin
    int fe0, ov0, v0, per, gap;
    longint dt;
    logic [7:0] b;
    logic good;

    rst      = 1'b1;
    rx_pin   = 1'b1;
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data",  32'(rx_data), 32'h0);
    check("reset_valid", 32'(rx_valid), 32'h0);
    check("reset_fe",    32'(frame_error), 32'h0);
    check("reset_ov",    32'(overrun_error), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(posedge clk);

    // Single byte, consumer always ready.
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = valid_cyc;
    send_frame(8'hA5, 1'b1, BIT_CLK);
    repeat (40) @(posedge clk);
    exp_q.push_back(8'hA5);
    compare_bytes("a5");
    check("a5_valid_len", 32'(valid_cyc - v0), 32'd1);
    check("a5_fe", 32'(fe_cnt - fe0), 32'd0);
    check("a5_ov", 32'(ov_cnt - ov0), 32'd0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, BIT_CLK);
    send_frame(8'hFF, 1'b1, BIT_CLK);
    repeat (40) @(posedge clk);
    dt = (got_t.size() == 2) ? (got_t[1] - got_t[0]) : 64'd0;
    check("b2b_gap", 32'((dt >= 1585 && dt <= 1615) ? 1 : 0), 32'd1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    compare_bytes("b2b");

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b1, BIT_CLK);
    send_frame(8'h5A, 1'b1, BIT_CLK);
    repeat (40) @(posedge clk);
    #1;
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_valid",  32'(rx_valid), 32'd1);
    check("ovr_data",   32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovr_valid_clear", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h3C);
    compare_bytes("ovr");

    // Short low glitch is rejected.
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = valid_cyc;
    rx_pin = 1'b0;
    repeat (40) @(posedge clk);
    rx_pin = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    check("glitch_valid", 32'(valid_cyc - v0), 32'd0);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_ov", 32'(ov_cnt - ov0), 32'd0);
    compare_bytes("glitch");

    // Framing error followed by a held-low line, then a good frame.
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0, BIT_CLK);
    rx_pin = 1'b0;
    repeat (3 * BIT_CLK) @(posedge clk);
    rx_pin = 1'b1;
    repeat (BIT_CLK) @(posedge clk);
    check("brk_fe_once", 32'(fe_cnt - fe0), 32'd1);
    send_frame(8'h81, 1'b1, BIT_CLK);
    repeat (40) @(posedge clk);
    check("brk_fe_total", 32'(fe_cnt - fe0), 32'd1);
    exp_q.push_back(8'h81);
    compare_bytes("brk");

    // Reset in the middle of data bit 4, with a held byte pending.
    rx_ready = 1'b0;
    send_frame(8'h96, 1'b1, BIT_CLK);
    repeat (40) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    b = 8'h55;
    rx_pin = 1'b0;
    repeat (BIT_CLK) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_pin = b[i];
      repeat (BIT_CLK) @(posedge clk);
    end
    rx_pin = b[4];
    repeat (BIT_CLK / 2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_data",  32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_fe",    32'(frame_error), 32'h0);
    check("rst_ov",    32'(overrun_error), 32'h0);
    fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    rx_pin   = 1'b1;
    rx_ready = 1'b1;
    repeat (BIT_CLK * 2) @(posedge clk);
    check("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);
    check("post_rst_ov", 32'(ov_cnt - ov0), 32'd0);
    check("post_rst_valid", 32'(rx_valid), 32'd0);
    send_frame(8'hC3, 1'b1, BIT_CLK);
    repeat (40) @(posedge clk);
    exp_q.push_back(8'hC3);
    compare_bytes("rst");

    // Randomized frames with small baud mismatch and occasional bad stop bits.
    fe0 = fe_cnt;
    for (int n = 0; n < 8; n++) begin
      int exp_fe;
      b    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 3) != 0);
      per  = $urandom_range(BIT_CLK - 4, BIT_CLK + 4);
      gap  = good ? $urandom_range(0, 30) : $urandom_range(20, 60);
      exp_fe = fe_cnt - fe0 + (good ? 0 : 1);
      send_frame(b, good, per);
      repeat (gap) @(posedge clk);
      if (good) exp_q.push_back(b);
      repeat (2) @(posedge clk);
      check("rand_fe", 32'(fe_cnt - fe0), 32'(exp_fe));
    end
    repeat (40) @(posedge clk);
    compare_bytes("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
